// File: rtl/tray_motion_monitor_pkg.sv
// Shared definitions for the tray motion monitor.
// Holds the tray_station output codes, the internal station/class enum and
// the enum-to-code mapping used by the top level.
package tray_motion_monitor_pkg;

    // Codes driven on tray_station
    localparam logic [7:0] TS_ZERO   = 8'h00;
    localparam logic [7:0] TS_STABLE = 8'h01;
    localparam logic [7:0] TS_MUP    = 8'h02;
    localparam logic [7:0] TS_MDW    = 8'h03;

    // Used both as the FSM state and as the per-sample class
    typedef enum logic [1:0] {
        StZero,
        StStable,
        StMup,
        StMdw
    } station_e;

    function automatic logic [7:0] station_code(input station_e s);
        logic [7:0] code;
        unique case (s)
            StZero:   code = TS_ZERO;
            StStable: code = TS_STABLE;
            StMup:    code = TS_MUP;
            StMdw:    code = TS_MDW;
            default:  code = TS_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tray_height_hist.sv
// Tray height history window.
// Keeps the last DEPTH accepted samples (rec[0] newest, rec[DEPTH-1] oldest),
// a fill counter saturating at DEPTH, and the registered newest-minus-oldest
// delta, which is valid once the window is full.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous clear of history and fill count (wins over push)
//   push, din     : accept din into rec[0], shifting older samples down
//   newest        : rec[0] as currently held (before any shift this cycle)
//   empty         : no sample accepted since reset/clear
//   height_delta  : signed rec[0] - rec[DEPTH-1] while delta_vld, else 0
//   delta_vld     : window holds DEPTH samples
module tray_height_hist #(
    parameter int unsigned HW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic [HW-1:0]      din,
    output logic [HW-1:0]      newest,
    output logic               empty,
    output logic signed [HW:0] height_delta,
    output logic               delta_vld
);

    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic [HW-1:0]      rec_q [DEPTH];
    logic [HW-1:0]      rec_d [DEPTH];
    logic [FW-1:0]      fill_q, fill_d;
    logic               dvld_q, dvld_d;
    logic signed [HW:0] delta_q, delta_d;

    always_comb begin
        rec_d  = rec_q;
        fill_d = fill_q;
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rec_d[i] = '0;
            end
            fill_d = '0;
        end else if (push) begin
            rec_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                rec_d[i] = rec_q[i-1];
            end
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // Delta is computed from the post-shift window so it lands with the sample
        dvld_d  = (fill_d == FULL);
        delta_d = dvld_d ? ($signed({1'b0, rec_d[0]}) - $signed({1'b0, rec_d[DEPTH-1]}))
                         : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rec_q[i] <= '0;
            end
            fill_q  <= '0;
            dvld_q  <= 1'b0;
            delta_q <= '0;
        end else begin
            rec_q   <= rec_d;
            fill_q  <= fill_d;
            dvld_q  <= dvld_d;
            delta_q <= delta_d;
        end
    end

    assign newest       = rec_q[0];
    assign empty        = (fill_q == '0);
    assign height_delta = delta_q;
    assign delta_vld    = dvld_q;

endmodule

// File: rtl/tray_motion_monitor.sv
// Tray motion monitor.
// Classifies each accepted tray height sample as zero / stable / up / down
// against the previous sample (with a deadband) and runs a confirmation FSM
// that only moves to a new non-zero station after CONFIRM consecutive samples
// of that class. A zero sample forces the ZERO station at once.
//   clk, rst_n       : clock, asynchronous active-low reset
//   sample_vld       : tray_height valid this cycle
//   tray_height      : unsigned height sample
//   clear            : synchronous clear of history and state (wins over sample_vld)
//   tray_station     : 00 zero, 01 stable, 02 moving up, 03 moving down
//   station_changed  : one-cycle pulse when tray_station takes a new value
//   height_delta     : signed newest minus oldest sample of the full window
//   delta_vld        : history window is full
module tray_motion_monitor
    import tray_motion_monitor_pkg::*;
#(
    parameter int unsigned HW       = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DEADBAND = 0,
    parameter int unsigned CONFIRM  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_vld,
    input  logic [HW-1:0]      tray_height,
    input  logic               clear,
    output logic [7:0]         tray_station,
    output logic               station_changed,
    output logic signed [HW:0] height_delta,
    output logic               delta_vld
);

    // The count only ever holds 0..CONFIRM-1; reaching CONFIRM commits the move
    localparam int unsigned CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM);
    localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM - 1);
    localparam logic [HW:0]   DB       = (HW+1)'(DEADBAND);

    logic [HW-1:0]      newest;
    logic               empty;

    tray_height_hist #(
        .HW    (HW),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .push         (sample_vld),
        .din          (tray_height),
        .newest       (newest),
        .empty        (empty),
        .height_delta (height_delta),
        .delta_vld    (delta_vld)
    );

    // Sample classifier
    logic signed [HW:0] step;
    logic [HW:0]        step_abs;
    station_e           cls;

    always_comb begin
        step     = $signed({1'b0, tray_height}) - $signed({1'b0, newest});
        step_abs = step[HW] ? $unsigned(-step) : $unsigned(step);
        if (tray_height == '0) begin
            cls = StZero;
        end else if (empty) begin
            cls = StStable;
        end else if (step_abs <= DB) begin
            cls = StStable;
        end else if (step[HW]) begin
            cls = StMdw;
        end else begin
            cls = StMup;
        end
    end

    // Confirmation FSM
    station_e          state_q, state_d;
    station_e          cand_q, cand_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        station_q;
    logic              changed_q;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = StZero;
            cand_d  = StZero;
            cnt_d   = '0;
        end else if (sample_vld) begin
            if (cls == StZero) begin
                // Tray at the floor: report it without confirmation
                state_d = StZero;
                cand_d  = StZero;
                cnt_d   = '0;
            end else if (empty) begin
                // First sample after reset/clear seeds the station directly
                state_d = StStable;
                cand_d  = StStable;
                cnt_d   = '0;
            end else if (cls == state_q) begin
                cnt_d = '0;
            end else if (cls == cand_q) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = cls;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = cls;
                if (CONFIRM == 1) begin
                    state_d = cls;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StZero;
            cand_q    <= StZero;
            cnt_q     <= '0;
            station_q <= TS_ZERO;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            station_q <= station_code(state_d);
            changed_q <= (state_d != state_q);
        end
    end

    assign tray_station    = station_q;
    assign station_changed = changed_q;

endmodule
